// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master: shifts a 1..7 byte command out on MOSI (MSB first)
// while capturing the same number of bytes from MISO. Every SPI pin is driven
// from a flop, so SCLK, SS and MOSI never glitch.
module spi_cmd_master #(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [8*MAX_BYTES-1:0]   tx_data,
    input  logic [2:0]               tx_len,
    output logic [8*MAX_BYTES-1:0]   rx_data,
    output logic                     busy,
    output logic                     done,
    output logic                     spi_clk,
    output logic                     spi_ss,
    output logic                     spi_mosi,
    input  logic                     spi_miso
);

    localparam int FRAME_W = 8 * MAX_BYTES;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           div_q, div_d;
    logic [CNT_W-1:0]     bits_q, bits_d;
    logic [2:0]           len_q, len_d;
    logic [FRAME_W-1:0]   tx_q, tx_d;
    logic [FRAME_W-1:0]   rx_sh_q, rx_sh_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ss_q, ss_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 div_last;
    logic                 active_d;

    // Received bits sit right-aligned in the shift register; move them to the top.
    function automatic logic [FRAME_W-1:0] align_rx(input logic [FRAME_W-1:0] sh,
                                                    input logic [2:0]         len);
        logic [CNT_W-1:0] amt;
        amt = CNT_W'(FRAME_W) - CNT_W'({len, 3'b000});
        return sh << amt;
    endfunction

    assign div_last = (div_q == DIV_LAST);

    // Next-state, datapath and registered-output decode for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q + 8'd1;
        bits_d    = bits_q;
        len_d     = len_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                div_d = 8'd0;
                if (start && (tx_len != 3'd0)) begin
                    tx_d    = tx_data;
                    len_d   = tx_len;
                    bits_d  = CNT_W'({tx_len, 3'b000});
                    rx_sh_d = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (div_last) begin
                    div_d   = 8'd0;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (div_last) begin
                    div_d   = 8'd0;
                    rx_sh_d = {rx_sh_q[FRAME_W-2:0], spi_miso};
                    bits_d  = bits_q - CNT_W'(1);
                    if (bits_q == CNT_W'(1)) begin
                        state_d = S_HOLD;
                    end else begin
                        tx_d    = {tx_q[FRAME_W-2:0], 1'b0};
                        state_d = S_LOW;
                    end
                end
            end
            S_LOW: begin
                if (div_last) begin
                    div_d   = 8'd0;
                    state_d = S_HIGH;
                end
            end
            S_HOLD: begin
                if (div_last) begin
                    div_d     = 8'd0;
                    done_d    = 1'b1;
                    rx_data_d = align_rx(rx_sh_q, len_q);
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (div_last) begin
                    div_d   = 8'd0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                div_d   = 8'd0;
                state_d = S_IDLE;
            end
        endcase

        active_d = (state_d inside {S_SETUP, S_HIGH, S_LOW, S_HOLD});
        busy_d   = (state_d != S_IDLE);
        ss_d     = !active_d;
        sclk_d   = (state_d == S_HIGH);
        mosi_d   = active_d & tx_d[FRAME_W-1];
    end

    // Control state and pin registers; reset returns the link to idle at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= 8'd0;
            bits_q    <= '0;
            len_q     <= 3'd0;
            rx_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ss_q      <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bits_q    <= bits_d;
            len_q     <= len_d;
            rx_data_q <= rx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ss_q      <= ss_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    // Shift registers carry data only; they are reloaded at every accepted start.
    always_ff @(posedge clk) begin
        tx_q    <= tx_d;
        rx_sh_q <= rx_sh_d;
    end

    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign spi_clk  = sclk_q;
    assign spi_ss   = ss_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench for spi_cmd_master. Three instances cover CLK_DIV = 1, 2 and 4:
// instance 0 talks to a mode-0 slave model, instance 1 has MISO looped to MOSI,
// instance 2 has MISO tied high.
module tb_spi_cmd_master;

    localparam logic [55:0] SLAVE_WORD = 56'hFEDCBA98765432;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic [55:0] tx_a [3];
    logic [2:0]  len_a [3];
    logic [55:0] rx_a [3];
    logic [2:0]  busy_v, done_v, sclk_v, ss_v, mosi_v;
    logic        miso0, miso1, miso2;

    logic [55:0] slave_sh = '0;
    logic [55:0] mosi_cap [3];
    logic [2:0]  sclk_prev = '0;
    int          rises [3];
    int          dones [3];
    int          ss_low [3];
    int          cyc = 0;
    int          c0 = 0;
    int          n_vec = 0;
    int          n_err = 0;

    assign miso0 = slave_sh[55];
    assign miso1 = mosi_v[1];
    assign miso2 = 1'b1;

    spi_cmd_master #(.CLK_DIV(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .tx_data(tx_a[0]), .tx_len(len_a[0]),
        .rx_data(rx_a[0]), .busy(busy_v[0]), .done(done_v[0]), .spi_clk(sclk_v[0]),
        .spi_ss(ss_v[0]), .spi_mosi(mosi_v[0]), .spi_miso(miso0));

    spi_cmd_master #(.CLK_DIV(2)) u_d2 (
        .clk(clk), .rst(rst), .start(start_v[1]), .tx_data(tx_a[1]), .tx_len(len_a[1]),
        .rx_data(rx_a[1]), .busy(busy_v[1]), .done(done_v[1]), .spi_clk(sclk_v[1]),
        .spi_ss(ss_v[1]), .spi_mosi(mosi_v[1]), .spi_miso(miso1));

    spi_cmd_master #(.CLK_DIV(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start_v[2]), .tx_data(tx_a[2]), .tx_len(len_a[2]),
        .rx_data(rx_a[2]), .busy(busy_v[2]), .done(done_v[2]), .spi_clk(sclk_v[2]),
        .spi_ss(ss_v[2]), .spi_mosi(mosi_v[2]), .spi_miso(miso2));

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle monitor: edge/pulse counters, MOSI capture and the mode-0 slave.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (sclk_v[i] && !sclk_prev[i]) begin
                rises[i]    <= rises[i] + 1;
                mosi_cap[i] <= {mosi_cap[i][54:0], mosi_v[i]};
            end
            if (done_v[i]) dones[i]  <= dones[i] + 1;
            if (!ss_v[i])  ss_low[i] <= ss_low[i] + 1;
        end
        sclk_prev <= sclk_v;
        if (ss_v[0])
            slave_sh <= SLAVE_WORD;
        else if (sclk_prev[0] && !sclk_v[0])
            slave_sh <= {slave_sh[54:0], 1'b0};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a one-cycle start; returns in cycle 1 of the frame.
    task automatic start_frame(input int s, input logic [55:0] d, input logic [2:0] n);
        tx_a[s]    = d;
        len_a[s]   = n;
        start_v[s] = 1'b1;
        c0 = cyc;
        step(1);
        start_v[s] = 1'b0;
    endtask

    // Bounded wait for busy to fall; reports relative cycles of done and busy fall.
    task automatic wait_done(input int s, input int limit, output int drel, output int brel);
        drel = -1;
        brel = -1;
        for (int k = 0; k < limit; k++) begin
            if (done_v[s]) drel = cyc - c0;
            if (!busy_v[s]) begin
                brel = cyc - c0;
                break;
            end
            step(1);
        end
    endtask

    int drel, brel, r0, d0, s0;

    initial begin
        rst     = 1'b1;
        start_v = '0;
        for (int i = 0; i < 3; i++) begin
            tx_a[i]  = '0;
            len_a[i] = '0;
        end
        step(3);
        check("rst_ss",   ss_v[1],   1);
        check("rst_sclk", sclk_v[1], 0);
        check("rst_mosi", mosi_v[1], 0);
        check("rst_busy", busy_v[1], 0);
        check("rst_done", done_v[1], 0);
        check("rst_rx",   rx_a[1],   0);
        rst = 1'b0;
        step(2);

        // CLK_DIV=2, one byte 0xA5, loopback
        r0 = rises[1]; d0 = dones[1]; s0 = ss_low[1];
        start_frame(1, 56'hA5000000000000, 3'd1);
        check("t1_c1_busy", busy_v[1], 1);
        check("t1_c1_ss",   ss_v[1],   0);
        check("t1_c1_mosi", mosi_v[1], 1);
        step(1);
        check("t1_c2_sclk", sclk_v[1], 0);
        step(1);
        check("t1_c3_sclk", sclk_v[1], 1);
        wait_done(1, 200, drel, brel);
        check("t1_done_cyc",  drel, 35);
        check("t1_busy_fall", brel, 37);
        check("t1_edges",  rises[1] - r0, 8);
        check("t1_dones",  dones[1] - d0, 1);
        check("t1_ss_low", ss_low[1] - s0, 34);
        check("t1_mosi_pat", mosi_cap[1][7:0], 8'hA5);
        check("t1_rx", rx_a[1], 56'hA5000000000000);
        step(2);

        // CLK_DIV=1, seven bytes against the slave model
        r0 = rises[0];
        start_frame(0, 56'h0123456789ABCD, 3'd7);
        wait_done(0, 400, drel, brel);
        check("t2_done_cyc",  drel, 114);
        check("t2_busy_fall", brel, 115);
        check("t2_edges", rises[0] - r0, 56);
        check("t2_slave_rx", mosi_cap[0], 56'h0123456789ABCD);
        check("t2_rx", rx_a[0], SLAVE_WORD);
        step(2);

        // CLK_DIV=4, three bytes, MISO high
        r0 = rises[2]; s0 = ss_low[2];
        start_frame(2, 56'h3C5A9600000000, 3'd3);
        wait_done(2, 400, drel, brel);
        check("t3_done_cyc",  drel, 197);
        check("t3_busy_fall", brel, 201);
        check("t3_edges",  rises[2] - r0, 24);
        check("t3_ss_low", ss_low[2] - s0, 196);
        check("t3_rx", rx_a[2], 56'hFFFFFF00000000);
        step(2);

        // Start pulses during a 2-byte frame are ignored; back-to-back start accepted
        r0 = rises[1]; d0 = dones[1];
        start_frame(1, 56'hC37E0000000000, 3'd2);
        step(4);
        tx_a[1] = 56'h11111111111111; len_a[1] = 3'd7; start_v[1] = 1'b1;
        step(1);
        start_v[1] = 1'b0;
        step(14);
        start_v[1] = 1'b1;
        step(1);
        start_v[1] = 1'b0;
        wait_done(1, 200, drel, brel);
        check("t4_done_cyc",  drel, 67);
        check("t4_busy_fall", brel, 69);
        check("t4_edges", rises[1] - r0, 16);
        check("t4_dones", dones[1] - d0, 1);
        check("t4_rx", rx_a[1], 56'hC37E0000000000);
        start_frame(1, 56'h5A000000000000, 3'd1);
        check("t4b_c1_busy", busy_v[1], 1);
        check("t4b_c1_ss",   ss_v[1],   0);
        wait_done(1, 200, drel, brel);
        check("t4b_done_cyc", drel, 35);
        check("t4b_rx", rx_a[1], 56'h5A000000000000);
        step(2);

        // tx_len=0 is ignored
        d0 = dones[1]; s0 = ss_low[1];
        start_frame(1, 56'hFFFFFFFFFFFFFF, 3'd0);
        check("t5_c1_busy", busy_v[1], 0);
        check("t5_c1_ss",   ss_v[1],   1);
        step(6);
        check("t5_busy",  busy_v[1], 0);
        check("t5_dones", dones[1] - d0, 0);
        check("t5_ss_low", ss_low[1] - s0, 0);
        check("t5_rx", rx_a[1], 56'h5A000000000000);

        // Reset after 10 SCLK edges of a 4-byte frame, with a start in the reset cycle
        r0 = rises[1]; d0 = dones[1];
        start_frame(1, 56'hDEADBEEF000000, 3'd4);
        for (int k = 0; k < 200; k++) begin
            if (rises[1] - r0 >= 10) break;
            step(1);
        end
        check("t6_edges_reached", rises[1] - r0, 10);
        rst = 1'b1;
        tx_a[1] = 56'h77000000000000; len_a[1] = 3'd1; start_v[1] = 1'b1;
        step(1);
        rst = 1'b0;
        start_v[1] = 1'b0;
        check("t6_ss",   ss_v[1],   1);
        check("t6_sclk", sclk_v[1], 0);
        check("t6_mosi", mosi_v[1], 0);
        check("t6_busy", busy_v[1], 0);
        check("t6_done", done_v[1], 0);
        check("t6_rx",   rx_a[1],   0);
        step(1);
        check("t6_no_start_busy", busy_v[1], 0);
        step(100);
        check("t6_no_done", dones[1] - d0, 0);
        start_frame(1, 56'h96000000000000, 3'd1);
        wait_done(1, 200, drel, brel);
        check("t6b_done_cyc", drel, 35);
        check("t6b_rx", rx_a[1], 56'h96000000000000);
        check("t6b_dones", dones[1] - d0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
